// File: rtl/calc_pkg.sv
// Shared calculator definitions: key codes, keypad scan FSM states, key map.
package calc_pkg;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_MUL = 4'hC;
  localparam logic [3:0] KEY_DIV = 4'hD;
  localparam logic [3:0] KEY_EQ  = 4'hE;
  localparam logic [3:0] KEY_ESC = 4'hF;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESS    = 2'd2,
    HOLD     = 2'd3
  } scan_state_e;

  // Physical keypad layout [row][col] to key code
  function automatic logic [3:0] map_key(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = 4'h0;
    case ({row, col})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = KEY_ADD;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = KEY_SUB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = KEY_MUL;
      4'hC: code = KEY_ESC;
      4'hD: code = 4'h0;
      4'hE: code = KEY_EQ;
      4'hF: code = KEY_DIV;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchronizer for the asynchronous, active-low keypad rows.
module keypad_row_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_i,
  output logic [3:0] row_o
);

  logic [3:0] meta_q;
  logic [3:0] sync_q;

  // Idle (all rows released) after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 4'hF;
      sync_q <= 4'hF;
    end else begin
      meta_q <= row_i;
      sync_q <= meta_q;
    end
  end

  assign row_o = sync_q;

endmodule

// File: rtl/keypad_scan_decoder.sv
// 4x4 keypad scanner: column scan, debounce, decode into one-cycle event pulses.
// Optional auto-repeat of held digit keys when KEYPAD_REPEAT_EN is defined.
module keypad_scan_decoder
  import calc_pkg::*;
#(
  parameter int unsigned SCAN_DIV         = 16,
  parameter int unsigned DEBOUNCE_SAMPLES = 4,
  parameter int unsigned REPEAT_SAMPLES   = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       got_dig,
  output logic       got_op,
  output logic       got_eq,
  output logic       got_esc
);

  localparam int unsigned SLOT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  // One counter width covers both the debounce and the repeat limits
  localparam int unsigned CNT_MAX = (DEBOUNCE_SAMPLES > REPEAT_SAMPLES) ? DEBOUNCE_SAMPLES
                                                                        : REPEAT_SAMPLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  scan_state_e       state_q, state_d;
  logic [SLOT_W-1:0] slot_q;
  logic [1:0]        col_q, col_d;
  logic [3:0]        col_out_q, col_out_d;
  logic [1:0]        cand_row_q, cand_row_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        key_code_q, key_code_d;
  logic              got_dig_q, got_dig_d;
  logic              got_op_q, got_op_d;
  logic              got_eq_q, got_eq_d;
  logic              got_esc_q, got_esc_d;
`ifdef KEYPAD_REPEAT_EN
  logic [CNT_W-1:0]  rep_cnt_q, rep_cnt_d;
`endif

  logic [3:0] row_s;
  logic       sample;
  logic       row_valid;
  logic [1:0] row_idx;
  logic       accept;
  logic [3:0] new_code;

  keypad_row_sync u_row_sync (
    .clk   (clk),
    .rst   (rst),
    .row_i (row_in),
    .row_o (row_s)
  );

  assign sample = (slot_q == SLOT_W'(SCAN_DIV - 1));

  // Free-running slot counter; rows are sampled in the last cycle of each slot
  always_ff @(posedge clk) begin
    if (rst) slot_q <= '0;
    else     slot_q <= sample ? '0 : slot_q + SLOT_W'(1);
  end

  // Exactly one low row is a valid key; none or several (ghosting) is "no key"
  always_comb begin
    row_valid = 1'b1;
    row_idx   = 2'd0;
    case (~row_s)
      4'b0001: row_idx = 2'd0;
      4'b0010: row_idx = 2'd1;
      4'b0100: row_idx = 2'd2;
      4'b1000: row_idx = 2'd3;
      default: row_valid = 1'b0;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SCAN;
      col_q      <= 2'd0;
      col_out_q  <= 4'b1110;
      cand_row_q <= 2'd0;
      cnt_q      <= '0;
      key_code_q <= 4'h0;
      got_dig_q  <= 1'b0;
      got_op_q   <= 1'b0;
      got_eq_q   <= 1'b0;
      got_esc_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      col_out_q  <= col_out_d;
      cand_row_q <= cand_row_d;
      cnt_q      <= cnt_d;
      key_code_q <= key_code_d;
      got_dig_q  <= got_dig_d;
      got_op_q   <= got_op_d;
      got_eq_q   <= got_eq_d;
      got_esc_q  <= got_esc_d;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_q  <= rep_cnt_d;
`endif
    end
  end

  // Scan/debounce FSM next state and decoded outputs
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    cand_row_d = cand_row_q;
    cnt_d      = cnt_q;
    key_code_d = key_code_q;
    got_dig_d  = 1'b0;
    got_op_d   = 1'b0;
    got_eq_d   = 1'b0;
    got_esc_d  = 1'b0;
    accept     = 1'b0;
    new_code   = map_key(row_idx, col_q);
`ifdef KEYPAD_REPEAT_EN
    rep_cnt_d  = rep_cnt_q;
`endif

    case (state_q)
      SCAN: begin
        if (sample) begin
          if (row_valid) begin
            cand_row_d = row_idx;
            cnt_d      = CNT_W'(1);
            if (DEBOUNCE_SAMPLES == 1) begin
              state_d = PRESS;
              accept  = 1'b1;
            end else begin
              state_d = DEBOUNCE;
            end
          end else begin
            col_d = col_q + 2'd1;
          end
        end
      end
      DEBOUNCE: begin
        if (sample) begin
          if (row_valid && (row_idx == cand_row_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_d == CNT_W'(DEBOUNCE_SAMPLES)) begin
              state_d = PRESS;
              accept  = 1'b1;
            end
          end else begin
            state_d = SCAN;
            col_d   = col_q + 2'd1;
            cnt_d   = '0;
          end
        end
      end
      PRESS: begin
        cnt_d   = '0;
        state_d = HOLD;
`ifdef KEYPAD_REPEAT_EN
        rep_cnt_d = '0;
`endif
      end
      HOLD: begin
        if (sample) begin
          if (row_valid) begin
            cnt_d = '0;
`ifdef KEYPAD_REPEAT_EN
            if ((row_idx == cand_row_q) && (key_code_q <= 4'd9)) begin
              rep_cnt_d = rep_cnt_q + CNT_W'(1);
              if (rep_cnt_d == CNT_W'(REPEAT_SAMPLES)) begin
                rep_cnt_d = '0;
                got_dig_d = 1'b1;
              end
            end
`endif
          end else if (cnt_q + CNT_W'(1) == CNT_W'(DEBOUNCE_SAMPLES)) begin
            state_d = SCAN;
            cnt_d   = '0;
            col_d   = col_q + 2'd1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = SCAN;
    endcase

    // Accepted key: latch code and raise the pulse for its class
    if (accept) begin
      key_code_d = new_code;
      if (new_code <= 4'd9)          got_dig_d = 1'b1;
      else if (new_code == KEY_EQ)   got_eq_d  = 1'b1;
      else if (new_code == KEY_ESC)  got_esc_d = 1'b1;
      else                           got_op_d  = 1'b1;
    end

    col_out_d = ~(4'b0001 << col_d);
  end

  assign col_out  = col_out_q;
  assign key_code = key_code_q;
  assign got_dig  = got_dig_q;
  assign got_op   = got_op_q;
  assign got_eq   = got_eq_q;
  assign got_esc  = got_esc_q;

endmodule
